keyboard_key_repeat: RTL and testbench
======================================

# keyboard_key_repeat

Multi-key PS/2 event decoder that generalises the single-key one-clock press detector. It watches the decoded keyboard event stream (scan code, make/break, valid strobe) for `NUM_KEYS` configurable scan codes. For each key it produces a level "held" flag, a one-cycle press pulse, and an auto-repeat pulse train (delayed auto-shift) for Tetris left/right/down movement. It sits between the keyboard receiver/FIFO and the game controller.

## Interface
Parameters:
- `NUM_KEYS`, 4: number of tracked keys.
- `SCAN_CODES`, {`SPACE_C`, 8'h1C, 8'h23, 8'h1B}: packed `NUM_KEYS*8` bits. Key i's code is bits [8i+7:8i], with key 0 in the LSBs.
- `REPEAT_MASK`, {NUM_KEYS{1'b1}}: bit i = 1 enables auto-repeat for key i.
- `DAS_DELAY`, 16: cycles from press pulse to first repeat pulse. Must be ≥ 1.
- `ARR_PERIOD`, 4: cycles between subsequent repeat pulses. Must be ≥ 1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `scanValid` in 1: one-cycle strobe; `scanCode`/`makeBreak` are valid this cycle.
- `scanCode` in 8: event scan code.
- `makeBreak` in 1: 1 = make (press), 0 = break (release).
- `held` out NUM_KEYS: level, key i currently down.
- `press` out NUM_KEYS: one-cycle pulse on key i's first make.
- `fire` out NUM_KEYS: one-cycle pulse on press, and again on each auto-repeat.

## Operation
- Each key has an independent FSM with states IDLE, DELAY and REPEAT, plus a down-counter of width `$clog2(max(DAS_DELAY,ARR_PERIOD)+1)`.
- An event matches key i when `scanValid` is 1 and `scanCode == SCAN_CODES[i]`. Events with `scanValid` = 0 are ignored regardless of `scanCode`. Unmatched codes never disturb any key's state.
- If several keys share a code, each of them responds independently.
- IDLE:
  - Make match → DELAY, counter = `DAS_DELAY-1`, pulse `press[i]` and `fire[i]`.
  - If `REPEAT_MASK[i]` = 0, a make match goes to a held state with no repeat (DELAY with the counter frozen). No further `fire` until break.
  - Break match → stay in IDLE.
- DELAY:
  - Counter decrements each cycle.
  - At 0 (and repeat enabled) → REPEAT, counter = `ARR_PERIOD-1`, pulse `fire[i]`.
- REPEAT:
  - Counter decrements.
  - At 0 → pulse `fire[i]` and reload `ARR_PERIOD-1`.
- Any state, break match → IDLE next cycle, counter cleared, no pulse. A break overrides a same-cycle counter expiry.
- Make match while in DELAY or REPEAT (keyboard typematic repeat) is ignored: no pulse and no counter restart.
- `held[i]` = (state != IDLE).

## Timing
- Reset: all FSMs IDLE, counters 0, `held`, `press` and `fire` all 0 in the cycle after `rst` is sampled high. `rst` wins over a same-cycle event.
- Reset mid-hold drops `held` immediately. A subsequent make produces a fresh press pulse.
- All outputs are registered.
- Make event sampled at edge N → `press`/`fire` high during cycle N+1 only. `held` rises in N+1.
- First repeat `fire` occurs exactly `DAS_DELAY` cycles after the press pulse (cycle N+1+DAS_DELAY). Later repeats occur every `ARR_PERIOD` cycles.
- Break sampled at edge M → `held` low in M+1. No `fire` in M+1 or later.
- `DAS_DELAY` = 1 gives a repeat on the cycle right after the press pulse. `ARR_PERIOD` = 1 gives `fire` high every cycle in REPEAT.
- Back-to-back events (`scanValid` high on consecutive cycles) are each processed. There is no backpressure.

## Test plan
Use `NUM_KEYS`=3, `SCAN_CODES`={8'h23,8'h1C,8'h29}, `REPEAT_MASK`=3'b110, `DAS_DELAY`=10, `ARR_PERIOD`=4.
- Reset, then make 8'h29 at cycle 0 → `press[0]`/`fire[0]` high at cycle 1 only. `held[0]` stays 1. No further `fire[0]` over 50 cycles (repeat masked).
- Make 8'h1C at cycle 0, hold 30 cycles → `fire[1]` at cycles 1, 11, 15, 19, 23, 27. `press[1]` at cycle 1 only.
- Make 8'h1C at cycle 0, break 8'h1C at cycle 10 (same cycle as the would-be repeat) → `fire[1]` only at cycle 1. `held[1]` = 0 from cycle 11.
- Hold 8'h23, re-send make 8'h23 every 3 cycles → repeat cadence unchanged, no extra `press[2]`.
- Make 8'h1C and 8'h23 on consecutive cycles; send unrelated 8'h15 and events with `scanValid`=0 → both keys track independently. Unrelated and invalid events cause no change.
- Hold 8'h1C in REPEAT, assert `rst` one cycle → all outputs 0 next cycle. A new make → `press[1]` pulses again.

Source files
------------

// File: rtl/keyboard_key_repeat.sv
// Multi-key PS/2 event decoder: per-key held level, one-cycle press pulse and
// a delayed-auto-shift repeat pulse train on fire.
module keyboard_key_repeat #(
  parameter int                    NUM_KEYS    = 4,
  parameter logic [NUM_KEYS*8-1:0] SCAN_CODES  = {8'h29, 8'h1C, 8'h23, 8'h1B},
  parameter logic [NUM_KEYS-1:0]   REPEAT_MASK = {NUM_KEYS{1'b1}},
  parameter int                    DAS_DELAY   = 16,
  parameter int                    ARR_PERIOD  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scanValid,
  input  logic [7:0]          scanCode,
  input  logic                makeBreak,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] fire
);

  localparam int MAX_PERIOD = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
  localparam int CW         = $clog2(MAX_PERIOD + 1);

  localparam logic [CW-1:0] DAS_RELOAD = CW'(DAS_DELAY - 1);
  localparam logic [CW-1:0] ARR_RELOAD = CW'(ARR_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          fire_q, fire_d;
    logic          hit, make_hit, break_hit;

    assign hit       = scanValid && (scanCode == SCAN_CODES[8*i +: 8]);
    assign make_hit  = hit && makeBreak;
    assign break_hit = hit && !makeBreak;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      fire_d  = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (make_hit) begin
            state_d = DELAY;
            cnt_d   = DAS_RELOAD;
            press_d = 1'b1;
            fire_d  = 1'b1;
          end
        end
        DELAY: begin
          // A break wins over a same-cycle expiry; typematic makes are ignored.
          if (break_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (REPEAT_MASK[i]) begin
            if (cnt_q == '0) begin
              state_d = REPEAT;
              cnt_d   = ARR_RELOAD;
              fire_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        REPEAT: begin
          if (break_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            cnt_d  = ARR_RELOAD;
            fire_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        press_q <= 1'b0;
        fire_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
        fire_q  <= fire_d;
      end
    end

    assign held[i]  = (state_q != IDLE);
    assign press[i] = press_q;
    assign fire[i]  = fire_q;
  end

endmodule

// File: tb/tb_keyboard_key_repeat.sv
// Self-checking bench for keyboard_key_repeat: directed vector table, corner
// sequences and randomized events against a time-based reference model.
module tb_keyboard_key_repeat;

  localparam int DAS = 10;
  localparam int ARR = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scanValid = 1'b0;
  logic [7:0] scanCode = 8'h00;
  logic       makeBreak = 1'b0;
  logic [2:0] held, press, fire;

  keyboard_key_repeat #(
    .NUM_KEYS   (3),
    .SCAN_CODES ({8'h23, 8'h1C, 8'h29}),
    .REPEAT_MASK(3'b110),
    .DAS_DELAY  (DAS),
    .ARR_PERIOD (ARR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scanValid(scanValid),
    .scanCode (scanCode),
    .makeBreak(makeBreak),
    .held     (held),
    .press    (press),
    .fire     (fire)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a key is either up or down since edge m_p; outputs are
  // a pure function of the edge count elapsed since that press.
  logic [7:0] codes [3];
  bit         rep   [3];
  bit         m_down[3];
  int         m_p   [3];
  int         ecount = 0;
  logic [2:0] exp_h, exp_p, exp_f;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, ecount);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [7:0] c, input logic m);
    ecount++;
    for (int k = 0; k < 3; k++) begin
      if (r) m_down[k] = 0;
      else if (v && c == codes[k]) begin
        if (m && !m_down[k]) begin
          m_down[k] = 1;
          m_p[k]    = ecount;
        end else if (!m) begin
          m_down[k] = 0;
        end
      end
      exp_h[k] = m_down[k];
      exp_p[k] = m_down[k] && (ecount == m_p[k]);
      exp_f[k] = m_down[k] && ((ecount == m_p[k]) ||
                 (rep[k] && (ecount - m_p[k] >= DAS) && ((ecount - m_p[k] - DAS) % ARR == 0)));
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] c, input logic m);
    rst = r; scanValid = v; scanCode = c; makeBreak = m;
    @(posedge clk);
    model_edge(r, v, c, m);
    #1;
    check("held_vs_model",  64'(held),  64'(exp_h));
    check("press_vs_model", 64'(press), 64'(exp_p));
    check("fire_vs_model",  64'(fire),  64'(exp_f));
  endtask

  typedef struct {
    logic       r, v;
    logic [7:0] code;
    logic       mk;
    logic [2:0] h, p, f;
  } vec_t;

  vec_t tbl [12];

  logic [63:0] got_mask, exp_mask;
  int          n_press;

  initial begin
    codes[0] = 8'h29; codes[1] = 8'h1C; codes[2] = 8'h23;
    rep[0] = 0; rep[1] = 1; rep[2] = 1;
    for (int k = 0; k < 3; k++) begin m_down[k] = 0; m_p[k] = 0; end

    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{1'b0, 1'b1, 8'h29, 1'b1, 3'b001, 3'b001, 3'b001};
    tbl[2]  = '{1'b0, 1'b0, 8'h29, 1'b0, 3'b001, 3'b000, 3'b000};
    tbl[3]  = '{1'b0, 1'b1, 8'h15, 1'b0, 3'b001, 3'b000, 3'b000};
    tbl[4]  = '{1'b0, 1'b1, 8'h1C, 1'b1, 3'b011, 3'b010, 3'b010};
    tbl[5]  = '{1'b0, 1'b1, 8'h29, 1'b0, 3'b010, 3'b000, 3'b000};
    tbl[6]  = '{1'b0, 1'b1, 8'h1C, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[7]  = '{1'b0, 1'b1, 8'h1C, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[8]  = '{1'b0, 1'b1, 8'h23, 1'b1, 3'b100, 3'b100, 3'b100};
    tbl[9]  = '{1'b0, 1'b1, 8'h23, 1'b1, 3'b100, 3'b000, 3'b000};
    tbl[10] = '{1'b1, 1'b1, 8'h1C, 1'b1, 3'b000, 3'b000, 3'b000};
    tbl[11] = '{1'b0, 1'b1, 8'h1C, 1'b1, 3'b010, 3'b010, 3'b010};

    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].code, tbl[i].mk);
      check($sformatf("tbl%0d_held", i),  64'(held),  64'(tbl[i].h));
      check($sformatf("tbl%0d_press", i), 64'(press), 64'(tbl[i].p));
      check($sformatf("tbl%0d_fire", i),  64'(fire),  64'(tbl[i].f));
    end

    // Masked key: one press/fire, then held with no repeats for 50 cycles.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    got_mask = '0;
    for (int k = 0; k < 50; k++) begin
      if (k == 0) step(1'b0, 1'b1, 8'h29, 1'b1);
      else        step(1'b0, 1'b0, 8'h00, 1'b0);
      if (fire[0]) got_mask[k+1] = 1'b1;
    end
    check("masked_fire_cycles", got_mask, 64'h2);
    check("masked_still_held", 64'(held[0]), 64'd1);

    // Repeating key held 30 cycles: fire at 1, 11, 15, 19, 23, 27.
    exp_mask = '0;
    exp_mask[1] = 1'b1;
    for (int c = 1 + DAS; c <= 30; c += ARR) exp_mask[c] = 1'b1;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    got_mask = '0; n_press = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 0) step(1'b0, 1'b1, 8'h1C, 1'b1);
      else        step(1'b0, 1'b0, 8'h00, 1'b0);
      if (fire[1]) got_mask[k+1] = 1'b1;
      if (press[1]) n_press++;
    end
    check("repeat_fire_cycles", got_mask, exp_mask);
    check("repeat_press_count", 64'(n_press), 64'd1);

    // Break on the cycle the first repeat would fire.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    got_mask = '0;
    for (int k = 0; k < 20; k++) begin
      if (k == 0)       step(1'b0, 1'b1, 8'h1C, 1'b1);
      else if (k == 10) step(1'b0, 1'b1, 8'h1C, 1'b0);
      else              step(1'b0, 1'b0, 8'h00, 1'b0);
      if (fire[1]) got_mask[k+1] = 1'b1;
      if (k == 10) check("break_held_low", 64'(held[1]), 64'd0);
    end
    check("break_fire_cycles", got_mask, 64'h2);

    // Typematic re-makes every 3 cycles leave the cadence untouched.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    got_mask = '0; n_press = 0;
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 0) step(1'b0, 1'b1, 8'h23, 1'b1);
      else            step(1'b0, 1'b0, 8'h00, 1'b0);
      if (fire[2]) got_mask[k+1] = 1'b1;
      if (press[2]) n_press++;
    end
    check("typematic_fire_cycles", got_mask, exp_mask);
    check("typematic_press_count", 64'(n_press), 64'd1);

    // Two keys back to back, with unrelated and invalid traffic.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h1C, 1'b1);
    step(1'b0, 1'b1, 8'h23, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) step(1'b0, 1'b1, 8'h15, k[2]);
      else            step(1'b0, 1'b0, (k[2] ? 8'h1C : 8'h23), 1'b0);
    end
    check("two_keys_held", 64'(held), 64'(3'b110));

    // Reset mid-repeat, then a fresh press.
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h1C, 1'b1);
    check("reset_outputs", 64'({held, press, fire}), 64'd0);
    step(1'b0, 1'b1, 8'h1C, 1'b1);
    check("press_after_reset", 64'(press), 64'(3'b010));

    // Randomized event stream.
    for (int k = 0; k < 1500; k++) begin
      logic [7:0] c;
      case ($urandom % 5)
        0: c = 8'h29;
        1: c = 8'h1C;
        2: c = 8'h23;
        3: c = 8'h15;
        default: c = 8'($urandom);
      endcase
      step(($urandom % 97) == 0, ($urandom % 3) == 0, c, ($urandom % 4) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
